// File: rtl/rk_word_packer.sv
// Packs 12-bit PDP-8 words into a 512-byte SD block (high byte first) and unpacks them again.
// Optional build macro RK_PACK_CHECK_EN: flags read bytes whose unused high nibble is non-zero.
module rk_word_packer #(
  parameter int SD_BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic        half,
  input  logic        abort,
  input  logic [0:11] word_in,
  input  logic        word_in_valid,
  output logic        word_in_ready,
  output logic [0:11] word_out,
  output logic        word_out_valid,
  input  logic        word_out_ready,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  output logic        busy,
  output logic        done,
  output logic        fmt_err
);

  typedef enum logic [3:0] {
    IDLE, WR_FETCH, WR_HI, WR_LO, WR_PAD, RD_HI, RD_LO, RD_WORD, RD_DRAIN, DONE
  } state_t;

  localparam logic [9:0] BLK = 10'(SD_BLOCK_BYTES);

  state_t      state, state_nxt;
  logic        half_q;
  logic [8:0]  wcnt;
  logic [9:0]  bcnt;
  logic [0:11] wbuf;
  logic [3:0]  hi_nib;

  logic start_acc, wi_hs, wo_hs, bi_hs, bo_hs, wcnt_last, bcnt_last;
  logic [8:0] n_words;

  assign start_acc = (state == IDLE) && start && !abort;
  assign wi_hs     = word_in_valid && word_in_ready;
  assign wo_hs     = word_out_valid && word_out_ready;
  assign bi_hs     = byte_in_valid && byte_in_ready;
  assign bo_hs     = byte_out_valid && byte_out_ready;
  assign n_words   = half_q ? 9'd128 : 9'd256;
  assign wcnt_last = (wcnt + 9'd1) == n_words;
  assign bcnt_last = (bcnt + 10'd1) == BLK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      half_q   <= 1'b0;
      wcnt     <= 9'd0;
      bcnt     <= 10'd0;
      word_out <= 12'o0000;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        half_q <= half;
        wcnt   <= 9'd0;
        bcnt   <= 10'd0;
      end else begin
        if ((bo_hs || bi_hs) && bcnt != BLK)
          bcnt <= bcnt + 10'd1;
        if (wo_hs || (state == WR_LO && bo_hs))
          wcnt <= wcnt + 9'd1;
      end
      if (state == RD_LO && bi_hs)
        word_out <= {hi_nib, byte_in};
    end
  end

  // Word and nibble holding registers carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (wi_hs)
      wbuf <= word_in;
    if (state == RD_HI && bi_hs)
      hi_nib <= byte_in[3:0];
  end

  always_comb begin
    state_nxt = state;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start_acc) state_nxt = dir ? WR_FETCH : RD_HI;
        WR_FETCH: if (wi_hs) state_nxt = WR_HI;
        WR_HI:    if (bo_hs) state_nxt = WR_LO;
        WR_LO:    if (bo_hs) state_nxt = !wcnt_last ? WR_FETCH : (bcnt_last ? DONE : WR_PAD);
        WR_PAD:   if (bo_hs && bcnt_last) state_nxt = DONE;
        RD_HI:    if (bi_hs) state_nxt = RD_LO;
        RD_LO:    if (bi_hs) state_nxt = RD_WORD;
        RD_WORD:  if (wo_hs) state_nxt = !wcnt_last ? RD_HI : ((bcnt == BLK) ? DONE : RD_DRAIN);
        RD_DRAIN: if (bi_hs && bcnt_last) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    word_in_ready  = (state == WR_FETCH);
    byte_out_valid = (state == WR_HI) || (state == WR_LO) || (state == WR_PAD);
    byte_in_ready  = (state == RD_HI) || (state == RD_LO) || (state == RD_DRAIN);
    word_out_valid = (state == RD_WORD);
    busy           = (state != IDLE) && (state != DONE);
    done           = (state == DONE);
    case (state)
      WR_HI:   byte_out = {4'b0000, wbuf[0:3]};
      WR_LO:   byte_out = wbuf[4:11];
      default: byte_out = 8'h00;
    endcase
  end

`ifdef RK_PACK_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fmt_err <= 1'b0;
    else if (start_acc)
      fmt_err <= 1'b0;
    else if (state == RD_HI && bi_hs && byte_in[7:4] != 4'h0)
      fmt_err <= 1'b1;
  end
`else
  assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_rk_word_packer.sv
// Directed bench for rk_word_packer: write/read sectors, padding, drain, backpressure, abort, format flag.
module tb_rk_word_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, dir = 1'b0, half = 1'b0, abort = 1'b0;
  logic [0:11] word_in;
  logic        word_in_valid = 1'b0;
  logic        word_in_ready;
  logic [0:11] word_out;
  logic        word_out_valid;
  logic        word_out_ready = 1'b1;
  logic [7:0]  byte_in;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_ready;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready = 1'b1;
  logic        busy, done, fmt_err;

  logic [0:11] src_w [0:255];
  logic [7:0]  src_b [0:511];
  logic [7:0]  got_b [0:1023];
  logic [0:11] got_w [0:511];
  int nw_in, nb_out, nb_in, nw_out, ndone;
  logic clr = 1'b0, rnd_en = 1'b0;
  int tests = 0, fails = 0;
  int cyc, first_bov, errs;
  logic busy_n1, busy_end, exp_fmt;

  rk_word_packer dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .half(half), .abort(abort),
    .word_in(word_in), .word_in_valid(word_in_valid), .word_in_ready(word_in_ready),
    .word_out(word_out), .word_out_valid(word_out_valid), .word_out_ready(word_out_ready),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      nw_in <= 0; nb_out <= 0; nb_in <= 0; nw_out <= 0; ndone <= 0;
    end else begin
      if (word_in_valid && word_in_ready) nw_in <= nw_in + 1;
      if (byte_out_valid && byte_out_ready) begin
        if (nb_out < 1024) got_b[nb_out] <= byte_out;
        nb_out <= nb_out + 1;
      end
      if (byte_in_valid && byte_in_ready) nb_in <= nb_in + 1;
      if (word_out_valid && word_out_ready) begin
        if (nw_out < 512) got_w[nw_out] <= word_out;
        nw_out <= nw_out + 1;
      end
      if (done) ndone <= ndone + 1;
    end
  end

  always_comb begin
    word_in = src_w[nw_in[7:0]];
    byte_in = src_b[nb_in[8:0]];
  end

  always @(negedge clk) begin
    byte_out_ready <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    word_out_ready <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic run(input logic d, input logic h);
    @(negedge clk); start = 1'b1; dir = d; half = h;
    @(negedge clk); start = 1'b0;
    cyc = 1; first_bov = 0; busy_n1 = busy;
    while (!done && cyc < 5000) begin
      if (byte_out_valid && first_bov == 0) first_bov = cyc;
      @(negedge clk); cyc++;
    end
    busy_end = busy;
    check("run_timeout", 32'(cyc < 5000), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input int k, input int nw);
    logic [0:11] w;
    if (k >= 2 * nw) return 8'h00;
    w = src_w[k / 2];
    return (k % 2 == 0) ? {4'b0000, w[0:3]} : w[4:11];
  endfunction

  initial begin
`ifdef RK_PACK_CHECK_EN
    exp_fmt = 1'b1;
`else
    exp_fmt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_ready_valid", {28'd0, word_in_ready, byte_in_ready, byte_out_valid, word_out_valid}, 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    reset = 1'b1;

    // Full 256-word write, sinks always ready
    for (int i = 0; i < 256; i++) src_w[i] = 12'(i);
    word_in_valid = 1'b1;
    clear_counts();
    run(1'b1, 1'b0);
    check("w256_busy_rise", 32'(busy_n1), 32'd1);
    check("w256_first_bov", 32'(first_bov), 32'd2);
    check("w256_cycles", 32'(cyc >= 769 && cyc <= 773), 32'd1);
    check("w256_busy_at_done", 32'(busy_end), 32'd0);
    check("w256_nbytes", 32'(nb_out), 32'd512);
    check("w256_nwords", 32'(nw_in), 32'd256);
    check("w256_b2", 32'(got_b[2]), 32'h00);
    check("w256_b3", 32'(got_b[3]), 32'h01);
    check("w256_b510", 32'(got_b[510]), 32'h00);
    check("w256_b511", 32'(got_b[511]), 32'hFF);
    check("w256_done_cnt", 32'(ndone), 32'd1);

    // 128-word write of all-ones words, padded
    for (int i = 0; i < 256; i++) src_w[i] = 12'o7777;
    clear_counts();
    run(1'b1, 1'b1);
    errs = 0;
    for (int k = 0; k < 512; k++)
      if (got_b[k] !== ((k >= 256) ? 8'h00 : ((k % 2 == 0) ? 8'h0F : 8'hFF))) errs++;
    check("w128_pad_bytes", 32'(errs), 32'd0);
    check("w128_nbytes", 32'(nb_out), 32'd512);
    check("w128_nwords", 32'(nw_in), 32'd128);
    check("w128_done_cnt", 32'(ndone), 32'd1);

    // 128-word read, remainder drained
    for (int k = 0; k < 512; k++) src_b[k] = (k % 2 == 0) ? 8'h05 : 8'h5A;
    word_in_valid = 1'b0;
    byte_in_valid = 1'b1;
    clear_counts();
    run(1'b0, 1'b1);
    errs = 0;
    for (int i = 0; i < 128; i++) if (got_w[i] !== 12'o2532) errs++;
    check("r128_words", 32'(errs), 32'd0);
    check("r128_nwords", 32'(nw_out), 32'd128);
    check("r128_nbytes", 32'(nb_in), 32'd512);
    check("r128_done_cnt", 32'(ndone), 32'd1);
    check("r128_fmt_clean", 32'(fmt_err), 32'd0);

    // 256-word write and read under random backpressure
    for (int i = 0; i < 256; i++) src_w[i] = 12'(i * 37 + 5);
    rnd_en = 1'b1;
    byte_in_valid = 1'b0;
    word_in_valid = 1'b1;
    clear_counts();
    run(1'b1, 1'b0);
    errs = 0;
    for (int k = 0; k < 512; k++) if (got_b[k] !== exp_byte(k, 256)) errs++;
    check("wbp_bytes", 32'(errs), 32'd0);
    check("wbp_nbytes", 32'(nb_out), 32'd512);
    check("wbp_done_cnt", 32'(ndone), 32'd1);

    for (int k = 0; k < 512; k++) src_b[k] = 8'($urandom);
    src_b[0] = 8'hA3;
    word_in_valid = 1'b0;
    byte_in_valid = 1'b1;
    clear_counts();
    run(1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (got_w[i] !== {src_b[2 * i][3:0], src_b[2 * i + 1]}) errs++;
    check("rbp_words", 32'(errs), 32'd0);
    check("rbp_nwords", 32'(nw_out), 32'd256);
    check("rbp_nbytes", 32'(nb_in), 32'd512);
    check("rbp_fmt_err", 32'(fmt_err), 32'(exp_fmt));
    rnd_en = 1'b0;

    // Abort at byte 100 of a write, then a clean sector
    for (int i = 0; i < 256; i++) src_w[i] = 12'(i * 5 + 3);
    byte_in_valid = 1'b0;
    word_in_valid = 1'b1;
    clear_counts();
    @(negedge clk); start = 1'b1; dir = 1'b1; half = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (nb_out < 100 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("abort_wait", 32'(cyc < 2000), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outputs", {30'd0, byte_out_valid, word_in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(ndone), 32'd0);
    clear_counts();
    run(1'b1, 1'b0);
    errs = 0;
    for (int k = 0; k < 512; k++) if (got_b[k] !== exp_byte(k, 256)) errs++;
    check("post_abort_bytes", 32'(errs), 32'd0);
    check("post_abort_nbytes", 32'(nb_out), 32'd512);
    check("post_abort_done", 32'(ndone), 32'd1);

    // start together with abort in IDLE is dropped
    @(negedge clk); start = 1'b1; abort = 1'b1; dir = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ready", 32'(word_in_ready), 32'd0);

    // Non-zero high nibble in a high byte
    for (int k = 0; k < 512; k++) src_b[k] = 8'h00;
    src_b[0] = 8'h35;
    src_b[1] = 8'h12;
    word_in_valid = 1'b0;
    byte_in_valid = 1'b1;
    clear_counts();
    run(1'b0, 1'b1);
    check("fmt_word", 32'(got_w[0]), 32'h512);
    check("fmt_flag", 32'(fmt_err), 32'(exp_fmt));
    byte_in_valid = 1'b0;
    word_in_valid = 1'b1;
    clear_counts();
    run(1'b1, 1'b1);
    check("fmt_cleared", 32'(fmt_err), 32'd0);
    check("fmt_next_nbytes", 32'(nb_out), 32'd512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
